// File: rtl/sum_bcd_display.sv
// sum_bcd_display
//   Captures a serial_adder sum on the rising edge of done, converts it to BCD
//   with an iterative shift-add-3 (double-dabble) FSM, and drives a multiplexed
//   active-low 7-segment display (segments {g,f,e,d,c,b,a}, an[0] = LS digit).
//   Optional feature macro: LEADING_ZERO_BLANK_EN blanks zero digits above the
//   most significant non-zero digit (digit 0 is always shown).
//   Legal configurations need 10**NUM_DIGITS > 2**SUM_W - 1.
module sum_bcd_display #(
  parameter int SUM_W      = 5,
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SUM_W-1:0]      sum,
  input  logic                  done,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  result_valid
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BIT_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t             state;
  logic               done_q;
  logic               cap;
  logic [SUM_W-1:0]   shift_reg;
  logic [BCD_W-1:0]   bcd_scr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;
  logic [SUM_W-1:0]   shift_next;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BCD_W-1:0]   bcd_disp;
  logic [CNT_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         cur_digit;
  logic [6:0]         seg_next;

  // Active-low 7-segment decode; out-of-range nibbles show blank.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction

  // done history; resets high so a done held through reset is not an edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b1;
    else        done_q <= done;
  end

  assign cap = done & ~done_q;

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift left.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bcd_adj = bcd_scr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_scr[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_scr[i*4 +: 4] + 4'd3;
    end
    {bcd_next, shift_next} = {bcd_adj, shift_reg} << 1;
  end

  // Conversion FSM; display register only updates when a conversion completes.
  // NOTE: datapath registers are reset too, keeping reset state fully deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bcd_scr      <= '0;
      bit_cnt      <= '0;
      bcd_disp     <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (cap) begin
        shift_reg <= sum;
        bcd_scr   <= '0;
        bit_cnt   <= '0;
        busy      <= 1'b1;
        state     <= CONVERT;
      end
    end else begin
      bcd_scr   <= bcd_next;
      shift_reg <= shift_next;
      if (bit_cnt == BIT_W'(SUM_W - 1)) begin
        bcd_disp     <= bcd_next;
        result_valid <= 1'b1;
        busy         <= 1'b0;
        state        <= IDLE;
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // Digit scan: SCAN_DIV clocks per slot, index wraps after the top digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  assign cur_digit = bcd_disp[idx*4 +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;

  // Blank digits that sit in the all-zero run above the most significant non-zero digit.
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (bcd_disp[i*4 +: 4] == 4'd0);
      blank[i]   = zero_above && (i != 0);
    end
  end

  assign seg_next = (!result_valid || blank[idx]) ? 7'h7F : decode(cur_digit);
`else
  assign seg_next = !result_valid ? 7'h7F : decode(cur_digit);
`endif

  // Registered display drive: follows index/display by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= 7'h7F;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_sum_bcd_display.sv
// tb_sum_bcd_display
//   Directed bench for sum_bcd_display with SCAN_DIV=4, SUM_W=5, NUM_DIGITS=2.
//   Expected segment patterns are hand-written constants.
module tb_sum_bcd_display;

  localparam logic [6:0] S_BLANK = 7'h7F;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = S_BLANK;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sum;
  logic       done;
  logic [6:0] seg;
  logic [1:0] an;
  logic       busy;
  logic       result_valid;

  int vectors     = 0;
  int miscompares = 0;

  sum_bcd_display #(.SUM_W(5), .NUM_DIGITS(2), .SCAN_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .sum          (sum),
    .done         (done),
    .seg          (seg),
    .an           (an),
    .busy         (busy),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " seg"},  32'(seg), 32'(S_BLANK));
    check({tag, " an"},   32'(an), 32'h3);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " rv"},   32'(result_valid), 32'h0);
  endtask

  // Raise done with a new sum and count busy-high cycles over a fixed window.
  task automatic run_conv(input logic [4:0] v, output int n);
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    sum  = v;
    done = 1'b1;
    n    = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    done = 1'b0;
  endtask

  // Watch one full scan period and check each slot against its expected digit.
  task automatic check_digits(input string tag, input logic [6:0] d0, input logic [6:0] d1);
    int n0 = 0;
    int n1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (an === 2'b10) begin
        n0++;
        check({tag, " digit0"}, 32'(seg), 32'(d0));
      end else if (an === 2'b01) begin
        n1++;
        check({tag, " digit1"}, 32'(seg), 32'(d1));
      end else begin
        check({tag, " an onehot"}, 32'(an), 32'h2);
      end
    end
    check({tag, " slots0"}, 32'(n0), 32'd4);
    check({tag, " slots1"}, 32'(n1), 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] exp_an;

    // Reset state.
    reset = 1'b0;
    done  = 1'b0;
    sum   = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");

    // Anode scan after release: 4 cycles per digit, wrapping after digit 1.
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_an = (((k - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
      check($sformatf("scan an k=%0d", k), 32'(an), 32'(exp_an));
    end
    check("blank before result", 32'(seg), 32'(S_BLANK));

    // 17 -> "17"; done stays high for the whole window: one conversion only.
    run_conv(5'd17, n);
    check("conv17 busy cycles", 32'(n), 32'd5);
    check("conv17 rv", 32'(result_valid), 32'h1);
    check_digits("conv17", S7, S1);

    // 3 -> leading zero behaviour.
    run_conv(5'd3, n);
    check("conv3 busy cycles", 32'(n), 32'd5);
    check_digits("conv3", S3, LZ);

    // 0 -> digit 0 always shown.
    run_conv(5'd0, n);
    check("conv0 busy cycles", 32'(n), 32'd5);
    check_digits("conv0", S0, LZ);

    // 31 is the largest input.
    run_conv(5'd31, n);
    check("conv31 busy cycles", 32'(n), 32'd5);
    check_digits("conv31", S1, S3);

    // Second done edge during CONVERT is ignored; sum changed mid-conversion is not used.
    @(negedge clk);
    sum  = 5'd25;
    done = 1'b1;               // cap at next edge N
    n    = 0;
    @(negedge clk); if (busy === 1'b1) n++;
    @(negedge clk); if (busy === 1'b1) n++;
    done = 1'b0;
    @(negedge clk); if (busy === 1'b1) n++;
    sum  = 5'd9;
    done = 1'b1;               // rising edge while converting
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    check("retrigger busy cycles", 32'(n), 32'd5);
    check_digits("retrigger", S5, S2);

    // Reset in the middle of a conversion with done held high.
    done = 1'b0;
    @(negedge clk);
    sum  = 5'd17;
    done = 1'b1;               // cap at edge N
    @(negedge clk);            // after N: loaded
    @(negedge clk);            // after N+1: iteration 1
    @(negedge clk);            // after N+2: iteration 2, iteration 3 in progress
    check("mid-conv busy", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check_reset_state("async reset");
    @(negedge clk);
    reset = 1'b1;              // done still high
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    check("held done no conv", 32'(n), 32'd0);
    check("held done rv", 32'(result_valid), 32'h0);
    check("held done seg", 32'(seg), 32'(S_BLANK));

    // Falling then rising done starts a fresh conversion.
    run_conv(5'd17, n);
    check("post-reset busy cycles", 32'(n), 32'd5);
    check_digits("post-reset", S7, S1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
